ex_bus_sequencer: RTL and testbench
===================================

Name: ex_bus_sequencer

Overview:
- Upstream driver of the external MSX cartridge-slot pins on the TN20K board.
- Takes internal Z80 bus cycles (bus_* signals, synchronous to clk_108m) and time-multiplexes address-low, address-high and data onto the shared 8-bit ex_bus_data pins through external latches.
- Drives the slot strobes and the transceiver direction, and returns read data and a wait request to the CPU.
- state_demux and counter_demux are exported for the bus debug probes.

Parameters:
- ADDR_CYCLES, 8, clk_108m cycles per address phase; legal range 4..31.
- TURN_CYCLES, 2, cycles after data-phase entry before read data is sampled; must be < SETTLE_CYCLES.
- SETTLE_CYCLES, 6, data-phase cycles before bus_wait_n may release; must be ≤ 31.

Ports:
- clk_108m  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- bus_mreq_n  in  1  internal memory request
- bus_iorq_n  in  1  internal IO request
- bus_rd_n  in  1  internal read strobe
- bus_wr_n  in  1  internal write strobe
- bus_addr  in  16  internal address
- bus_data  in  8  CPU write data
- ex_bus_data_in  in  8  pin input data
- ex_bus_wait_n  in  1  slot WAIT, asynchronous
- ex_bus_data_out  out  8  pin output data
- ex_bus_data_oe  out  1  FPGA pin drive enable
- ex_bus_data_reverse_n  out  1  transceiver direction: 1 = FPGA→slot, 0 = slot→FPGA
- le_addr_lo  out  1  A7..A0 latch enable
- le_addr_hi  out  1  A15..A8 latch enable
- ex_bus_mreq_n  out  1  slot MREQ
- ex_bus_iorq_n  out  1  slot IORQ
- ex_bus_rd_n  out  1  slot RD
- ex_bus_wr_n  out  1  slot WR
- cpu_data_out  out  8  read data to CPU
- bus_wait_n  out  1  wait to CPU
- state_demux  out  2  current state
- counter_demux  out  5  phase counter

Behaviour:
- All outputs are registered.
- Reset values:
  - Strobes, le_*, data_oe: strobes = 1, le_* = 0, data_oe = 0.
  - Transceiver and data: reverse_n = 0, data_out = 0x00, cpu_data_out = 0xFF.
  - Handshake and status: bus_wait_n = 1, state = IDLE (0), counter = 0.
- Reset asserted mid-cycle forces all outputs to these values on the next edge.
- req is high when exactly one of mreq/iorq is low AND exactly one of rd/wr is low.
  - Any other combination counts as no request.
  - The cycle kind (mem/io, read/write) is latched at start.
- States:
  - IDLE = 0: pins not driven, reverse_n = 0.
    - req high → ADDR_LO.
    - Same edge: bus_wait_n ← 0, data_out ← bus_addr[7:0], oe ← 1, reverse_n ← 1.
  - ADDR_LO = 1: le_addr_lo = 1 for counter in 1..ADDR_CYCLES-2.
    - At counter = ADDR_CYCLES-1 → ADDR_HI, with data_out ← bus_addr[15:8].
  - ADDR_HI = 2: le_addr_hi is timed the same way.
    - At counter = ADDR_CYCLES-1 → DATA.
  - DATA = 3, on entry:
    - Latched mreq_n or iorq_n is asserted.
    - Write: data_out ← bus_data, oe stays 1; ex_bus_wr_n asserts at counter = 1 (data set up one cycle ahead).
    - Read: oe ← 0 on entry, reverse_n ← 0 at counter = 1, ex_bus_rd_n asserts on entry.
    - Read capture: cpu_data_out ← ex_bus_data_in every cycle with counter ≥ TURN_CYCLES while in DATA.
    - Exit: req low → IDLE next edge. Strobes deassert, oe ← 0 and reverse_n ← 0 on that same edge; cpu_data_out holds.
- Counter:
  - Cleared to 0 on every state change.
  - Otherwise increments, saturating at 31.
- bus_wait_n:
  - Low from the edge ADDR_LO is entered until state = DATA with counter ≥ SETTLE_CYCLES.
  - After that it follows ex_bus_wait_n through a 2-flop synchroniser, so slot WAIT extends the cycle.
  - Returns to 1 in IDLE.
- Abort: req dropping in ADDR_LO or ADDR_HI → IDLE next edge, no slot strobe asserted, cpu_data_out unchanged.
- req changing kind mid-cycle: ignored, because the latched kind is used until IDLE.
- Back-to-back cycles: req high again in IDLE starts a new cycle on the next edge. IDLE therefore lasts at least one cycle.
- Address for ADDR_HI is sampled at ADDR_HI entry, not at cycle start.

Decomposition:
- Package msx_bus_pkg holds:
  - the state enum: IDLE / ADDR_LO / ADDR_HI / DATA, encoded 0..3;
  - the cycle-kind encoding;
  - the reset constants 0xFF and 0x00.
- One sub-module, sync_2ff, is used for ex_bus_wait_n.

Test Plan:
- Memory write: mreq_n = 0, wr_n = 0, addr = 0x4123, data = 0x5A, ex_bus_wait_n = 1.
  - data_out = 0x23 during ADDR_LO with le_addr_lo pulsing 6 cycles, then 0x41 with le_addr_hi.
  - Then 0x5A with ex_bus_wr_n low from DATA counter 1.
  - bus_wait_n releases at DATA counter 6.
- IO read: iorq_n = 0, rd_n = 0, addr = 0x0098, pins = 0xC3.
  - oe drops at DATA entry, reverse_n = 0 at counter 1.
  - cpu_data_out = 0xC3 from counter 2; holds 0xC3 after req drops.
- Slot wait: hold ex_bus_wait_n = 0 for 20 cycles during DATA.
  - bus_wait_n stays low until 2 cycles after ex_bus_wait_n rises.
- Abort: drop mreq_n at ADDR_HI counter 3.
  - Next edge state = 0, all strobes 1, oe = 0, bus_wait_n = 1.
- Illegal request: rd_n = wr_n = 0 → no state change. Reset at DATA counter 4 of a write → all outputs at reset values on the next edge.
- Back-to-back: two writes separated by one idle cycle.
  - Both complete; counter_demux and state_demux sequence 0→1→2→3→0→1.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX external slot bus sequencer.
package msx_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_LO = 2'd1,
    ADDR_HI = 2'd2,
    DATA    = 2'd3
  } bus_state_e;

  // Bit 1 selects IO space, bit 0 selects a read.
  typedef enum logic [1:0] {
    KIND_MEM_WR = 2'b00,
    KIND_MEM_RD = 2'b01,
    KIND_IO_WR  = 2'b10,
    KIND_IO_RD  = 2'b11
  } bus_kind_e;

  localparam logic [7:0] CPU_DATA_RST = 8'hFF;
  localparam logic [7:0] PIN_DATA_RST = 8'h00;
  localparam logic [4:0] CNT_MAX      = 5'd31;

  function automatic bus_kind_e decode_kind(input logic iorq_n, input logic rd_n);
    return bus_kind_e'({~iorq_n, ~rd_n});
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ex_bus_sequencer.sv
// Multiplexes Z80 bus cycles onto the MSX slot pins: address low, address high, then data.
//   state   | meaning
//   IDLE    | pins released, waiting for a single well-formed request
//   ADDR_LO | A7..A0 on the pins, le_addr_lo pulsed mid-phase
//   ADDR_HI | A15..A8 on the pins, le_addr_hi pulsed mid-phase
//   DATA    | slot strobes active until the CPU request drops
module ex_bus_sequencer
  import msx_bus_pkg::*;
#(
  parameter int ADDR_CYCLES   = 8,
  parameter int TURN_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic        clk_108m,
  input  logic        reset_n,
  input  logic        bus_mreq_n,
  input  logic        bus_iorq_n,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  input  logic [7:0]  ex_bus_data_in,
  input  logic        ex_bus_wait_n,
  output logic [7:0]  ex_bus_data_out,
  output logic        ex_bus_data_oe,
  output logic        ex_bus_data_reverse_n,
  output logic        le_addr_lo,
  output logic        le_addr_hi,
  output logic        ex_bus_mreq_n,
  output logic        ex_bus_iorq_n,
  output logic        ex_bus_rd_n,
  output logic        ex_bus_wr_n,
  output logic [7:0]  cpu_data_out,
  output logic        bus_wait_n,
  output logic [1:0]  state_demux,
  output logic [4:0]  counter_demux
);

  localparam logic [4:0] AC_LAST  = 5'(ADDR_CYCLES - 1);
  localparam logic [4:0] LE_LAST  = 5'(ADDR_CYCLES - 2);
  localparam logic [4:0] TURN_C   = 5'(TURN_CYCLES);
  localparam logic [4:0] SETTLE_C = 5'(SETTLE_CYCLES);

  bus_state_e state_q, state_d;
  bus_kind_e  kind_q, kind_d;
  logic [4:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] cpu_data_q, cpu_data_d;
  logic       oe_q, oe_d, rev_q, rev_d;
  logic       le_lo_q, le_lo_d, le_hi_q, le_hi_d;
  logic       mreq_q, mreq_d, iorq_q, iorq_d, rd_q, rd_d, wr_q, wr_d;
  logic       wait_q, wait_d;
  logic       req, slot_wait_sync, in_data, rd_cyc, io_cyc;

  // Exactly one space strobe and exactly one direction strobe; anything else is no request.
  assign req     = (bus_mreq_n ^ bus_iorq_n) & (bus_rd_n ^ bus_wr_n);
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
  assign rd_cyc  = (kind_q == KIND_MEM_RD) || (kind_q == KIND_IO_RD);
  assign io_cyc  = (kind_q == KIND_IO_WR) || (kind_q == KIND_IO_RD);

  sync_2ff #(.RST_VAL(1'b1)) u_wait_sync (
    .clk_i   (clk_108m),
    .rst_n_i (reset_n),
    .d_i     (ex_bus_wait_n),
    .q_o     (slot_wait_sync)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    data_out_d = data_out_q;
    cpu_data_d = cpu_data_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d    = ADDR_LO;
        kind_d     = decode_kind(bus_iorq_n, bus_rd_n);
        data_out_d = bus_addr[7:0];
      end
      ADDR_LO: if (!req) state_d = IDLE;
        else if (cnt_q == AC_LAST) begin
          state_d    = ADDR_HI;
          data_out_d = bus_addr[15:8];
        end
      ADDR_HI: if (!req) state_d = IDLE;
        else if (cnt_q == AC_LAST) begin
          state_d = DATA;
          if (!rd_cyc) data_out_d = bus_data;
        end
      DATA: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 5'd0 : cnt_inc;

    // Outputs are derived from the next state so they line up with state_demux/counter_demux.
    in_data = (state_d == DATA);
    oe_d    = (state_d != IDLE) && !(in_data && rd_cyc);
    rev_d   = (state_d != IDLE) && !(in_data && rd_cyc && cnt_d >= 5'd1);
    le_lo_d = (state_d == ADDR_LO) && (cnt_d >= 5'd1) && (cnt_d <= LE_LAST);
    le_hi_d = (state_d == ADDR_HI) && (cnt_d >= 5'd1) && (cnt_d <= LE_LAST);
    mreq_d  = !(in_data && !io_cyc);
    iorq_d  = !(in_data && io_cyc);
    rd_d    = !(in_data && rd_cyc);
    wr_d    = !(in_data && !rd_cyc && cnt_d >= 5'd1);
    if (in_data && rd_cyc && cnt_d >= TURN_C) cpu_data_d = ex_bus_data_in;

    if (state_d == IDLE) wait_d = 1'b1;
    else if (in_data && cnt_d >= SETTLE_C) wait_d = slot_wait_sync;
    else wait_d = 1'b0;
  end

  always_ff @(posedge clk_108m) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      kind_q     <= KIND_MEM_WR;
      cnt_q      <= 5'd0;
      data_out_q <= PIN_DATA_RST;
      cpu_data_q <= CPU_DATA_RST;
      oe_q       <= 1'b0;
      rev_q      <= 1'b0;
      le_lo_q    <= 1'b0;
      le_hi_q    <= 1'b0;
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      wait_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      cpu_data_q <= cpu_data_d;
      oe_q       <= oe_d;
      rev_q      <= rev_d;
      le_lo_q    <= le_lo_d;
      le_hi_q    <= le_hi_d;
      mreq_q     <= mreq_d;
      iorq_q     <= iorq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wait_q     <= wait_d;
    end
  end

  assign ex_bus_data_out       = data_out_q;
  assign ex_bus_data_oe        = oe_q;
  assign ex_bus_data_reverse_n = rev_q;
  assign le_addr_lo            = le_lo_q;
  assign le_addr_hi            = le_hi_q;
  assign ex_bus_mreq_n         = mreq_q;
  assign ex_bus_iorq_n         = iorq_q;
  assign ex_bus_rd_n           = rd_q;
  assign ex_bus_wr_n           = wr_q;
  assign cpu_data_out          = cpu_data_q;
  assign bus_wait_n            = wait_q;
  assign state_demux           = state_q;
  assign counter_demux         = cnt_q;

endmodule

// File: tb/tb_ex_bus_sequencer.sv
// Self-checking bench for ex_bus_sequencer: decode table, directed corner cases, random cycles vs a timeline model.
module tb_ex_bus_sequencer;

  localparam int AC     = 8;
  localparam int TURN   = 2;
  localparam int SETTLE = 6;

  logic        clk_108m = 1'b0;
  logic        reset_n;
  logic        bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic [7:0]  ex_bus_data_in;
  logic        ex_bus_wait_n;
  logic [7:0]  ex_bus_data_out;
  logic        ex_bus_data_oe, ex_bus_data_reverse_n;
  logic        le_addr_lo, le_addr_hi;
  logic        ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n, ex_bus_wr_n;
  logic [7:0]  cpu_data_out;
  logic        bus_wait_n;
  logic [1:0]  state_demux;
  logic [4:0]  counter_demux;

  always #5 clk_108m = ~clk_108m;

  typedef struct packed {
    logic [1:0] st;
    logic [4:0] cnt;
    logic [7:0] dout;
    logic       oe, rev, le_lo, le_hi, mreq, iorq, rd, wr;
    logic [7:0] cpu;
    logic       wt;
  } obs_t;

  typedef struct packed {
    logic [3:0] strobes;
    logic [1:0] st;
    logic       wt;
    logic       oe;
    logic [7:0] dout;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  logic [1:0] seq[$];

  ex_bus_sequencer #(.ADDR_CYCLES(AC), .TURN_CYCLES(TURN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_108m(clk_108m), .reset_n(reset_n),
    .bus_mreq_n(bus_mreq_n), .bus_iorq_n(bus_iorq_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_addr(bus_addr), .bus_data(bus_data),
    .ex_bus_data_in(ex_bus_data_in), .ex_bus_wait_n(ex_bus_wait_n),
    .ex_bus_data_out(ex_bus_data_out), .ex_bus_data_oe(ex_bus_data_oe),
    .ex_bus_data_reverse_n(ex_bus_data_reverse_n),
    .le_addr_lo(le_addr_lo), .le_addr_hi(le_addr_hi),
    .ex_bus_mreq_n(ex_bus_mreq_n), .ex_bus_iorq_n(ex_bus_iorq_n),
    .ex_bus_rd_n(ex_bus_rd_n), .ex_bus_wr_n(ex_bus_wr_n),
    .cpu_data_out(cpu_data_out), .bus_wait_n(bus_wait_n),
    .state_demux(state_demux), .counter_demux(counter_demux)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = state_demux; o.cnt = counter_demux; o.dout = ex_bus_data_out;
    o.oe = ex_bus_data_oe; o.rev = ex_bus_data_reverse_n;
    o.le_lo = le_addr_lo; o.le_hi = le_addr_hi;
    o.mreq = ex_bus_mreq_n; o.iorq = ex_bus_iorq_n; o.rd = ex_bus_rd_n; o.wr = ex_bus_wr_n;
    o.cpu = cpu_data_out; o.wt = bus_wait_n;
    return o;
  endfunction

  function automatic obs_t idle_obs(input int cnt, input logic [7:0] dout, input logic [7:0] cpu);
    obs_t o;
    o.st = 2'd0; o.cnt = 5'((cnt > 31) ? 31 : cnt); o.dout = dout;
    o.oe = 1'b0; o.rev = 1'b0; o.le_lo = 1'b0; o.le_hi = 1'b0;
    o.mreq = 1'b1; o.iorq = 1'b1; o.rd = 1'b1; o.wr = 1'b1;
    o.cpu = cpu; o.wt = 1'b1;
    return o;
  endfunction

  // Edge t (1 = the start edge) of an uninterrupted cycle lands in this phase/count.
  function automatic int phase_of(input int t);
    if (t <= AC) return 1;
    if (t <= 2 * AC) return 2;
    return 3;
  endfunction

  function automatic int cnt_of(input int t);
    int c;
    if (t <= AC) return t - 1;
    if (t <= 2 * AC) return t - AC - 1;
    c = t - 2 * AC - 1;
    return (c > 31) ? 31 : c;
  endfunction

  function automatic obs_t active_obs(input int t, input bit io, input bit rd,
                                      input logic [7:0] dout, input logic [7:0] cpu);
    obs_t o;
    int ph, c;
    bit dat;
    ph = phase_of(t); c = cnt_of(t); dat = (ph == 3);
    o.st = 2'(ph); o.cnt = 5'(c); o.dout = dout;
    o.oe    = !(dat && rd);
    o.rev   = !(dat && rd && c >= 1);
    o.le_lo = (ph == 1) && (c >= 1) && (c <= AC - 2);
    o.le_hi = (ph == 2) && (c >= 1) && (c <= AC - 2);
    o.mreq  = !(dat && !io);
    o.iorq  = !(dat && io);
    o.rd    = !(dat && rd);
    o.wr    = !(dat && !rd && c >= 1);
    o.cpu   = cpu;
    o.wt    = dat && (c >= SETTLE);
    return o;
  endfunction

  function automatic logic [3:0] req_strobes(input bit io, input bit rd);
    return {io, ~io, ~rd, rd};
  endfunction

  function automatic bit is_req(input logic [3:0] s);
    return bit'((s[3] ^ s[2]) & (s[1] ^ s[0]));
  endfunction

  task automatic drive_strobes(input logic [3:0] s);
    {bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n} = s;
  endtask

  task automatic step();
    @(posedge clk_108m);
    #1;
  endtask

  task automatic step_log();
    step();
    if (seq.size() == 0 || seq[$] != state_demux) seq.push_back(state_demux);
  endtask

  task automatic do_reset();
    drive_strobes(4'b1111);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic run_to(input int st, input int cnt, input string name);
    int k;
    k = 0;
    while (!(int'(state_demux) == st && int'(counter_demux) == cnt) && k < 100) begin
      step_log();
      k++;
    end
    check({name, " reached"}, 32'({state_demux, counter_demux}), 32'({2'(st), 5'(cnt)}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    logic [7:0] m_dout, m_cpu;
    int le_lo_n, le_hi_n, idle_n, wr_n_cnt;
    bit ok_lo, ok_hi, ok_wait;
    int exp_seq[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

    vecs = '{
      '{4'b0000, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b0001, 2'd0, 1'b1, 1'b0, 8'h00},
      '{4'b0010, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b0011, 2'd0, 1'b1, 1'b0, 8'h00},
      '{4'b0100, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b0101, 2'd1, 1'b0, 1'b1, 8'hEF},
      '{4'b0110, 2'd1, 1'b0, 1'b1, 8'hEF}, '{4'b0111, 2'd0, 1'b1, 1'b0, 8'h00},
      '{4'b1000, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b1001, 2'd1, 1'b0, 1'b1, 8'hEF},
      '{4'b1010, 2'd1, 1'b0, 1'b1, 8'hEF}, '{4'b1011, 2'd0, 1'b1, 1'b0, 8'h00},
      '{4'b1100, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b1101, 2'd0, 1'b1, 1'b0, 8'h00},
      '{4'b1110, 2'd0, 1'b1, 1'b0, 8'h00}, '{4'b1111, 2'd0, 1'b1, 1'b0, 8'h00}
    };

    reset_n = 1'b0;
    drive_strobes(4'b1111);
    bus_addr = 16'h0000; bus_data = 8'h00; ex_bus_data_in = 8'h00; ex_bus_wait_n = 1'b1;
    step(); step();
    check("reset values", sample(), idle_obs(0, 8'h00, 8'hFF));
    reset_n = 1'b1;

    // Request decode from IDLE, including illegal strobe combinations.
    bus_addr = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      do_reset();
      drive_strobes(vecs[i].strobes);
      step();
      check($sformatf("decode %b", vecs[i].strobes),
            32'({state_demux, bus_wait_n, ex_bus_data_oe, ex_bus_data_out}),
            32'({vecs[i].st, vecs[i].wt, vecs[i].oe, vecs[i].dout}));
      drive_strobes(4'b1111);
    end

    do_reset();
    repeat (40) step();
    check("idle counter saturates", 32'(counter_demux), 32'd31);

    // Memory write 0x4123 <- 0x5A.
    do_reset();
    bus_addr = 16'h4123; bus_data = 8'h5A;
    drive_strobes(req_strobes(1'b0, 1'b0));
    le_lo_n = 0; le_hi_n = 0; ok_lo = 1; ok_hi = 1;
    for (int k = 0; k < 2 * AC + 8; k++) begin
      step();
      if (state_demux == 2'd1) begin
        if (ex_bus_data_out != 8'h23) ok_lo = 0;
        le_lo_n += int'(le_addr_lo);
      end
      if (state_demux == 2'd2) begin
        if (ex_bus_data_out != 8'h41) ok_hi = 0;
        le_hi_n += int'(le_addr_hi);
      end
      if (state_demux == 2'd3) begin
        if (counter_demux == 5'd0)
          check("wr data0", 32'({ex_bus_data_out, ex_bus_wr_n, ex_bus_mreq_n, ex_bus_data_oe}),
                32'({8'h5A, 1'b1, 1'b0, 1'b1}));
        if (counter_demux == 5'd1) check("wr strobe c1", 32'(ex_bus_wr_n), 32'd0);
        if (counter_demux == 5'd5) check("wr wait c5", 32'(bus_wait_n), 32'd0);
        if (counter_demux == 5'd6) check("wr wait c6", 32'(bus_wait_n), 32'd1);
      end
    end
    check("wr addr lo byte", 32'(ok_lo), 32'd1);
    check("wr addr hi byte", 32'(ok_hi), 32'd1);
    check("wr le_lo pulses", 32'(le_lo_n), 32'd6);
    check("wr le_hi pulses", 32'(le_hi_n), 32'd6);
    drive_strobes(4'b1111);
    step();
    check("wr exit", sample(), idle_obs(0, 8'h5A, 8'hFF));

    // IO read 0x0098, slot returns 0xC3.
    do_reset();
    bus_addr = 16'h0098; ex_bus_data_in = 8'hC3;
    drive_strobes(req_strobes(1'b1, 1'b1));
    run_to(3, 0, "rd data entry");
    check("rd entry", 32'({ex_bus_data_oe, ex_bus_data_reverse_n, ex_bus_rd_n, ex_bus_iorq_n, ex_bus_mreq_n}),
          32'(5'b01001));
    step();
    check("rd c1", 32'({ex_bus_data_reverse_n, cpu_data_out}), 32'({1'b0, 8'hFF}));
    step();
    check("rd c2 capture", 32'(cpu_data_out), 32'h0000_00C3);
    step(); step();
    ex_bus_data_in = 8'h11;
    drive_strobes(4'b1111);
    step();
    check("rd exit hold", sample(), idle_obs(0, 8'h00, 8'hC3));

    // Slot WAIT held low through DATA.
    do_reset();
    bus_addr = 16'h1234; bus_data = 8'h77; ex_bus_wait_n = 1'b0;
    drive_strobes(req_strobes(1'b0, 1'b0));
    ok_wait = 1;
    for (int k = 0; k < 2 * AC + 20; k++) begin
      step();
      if (bus_wait_n !== 1'b0) ok_wait = 0;
    end
    check("slot wait held", 32'({ok_wait, state_demux, counter_demux}), 32'({1'b1, 2'd3, 5'd19}));
    ex_bus_wait_n = 1'b1;
    step();
    check("slot wait sync edge1", 32'(bus_wait_n), 32'd0);
    step(); step();
    check("slot wait release", 32'(bus_wait_n), 32'd1);
    drive_strobes(4'b1111);
    step();

    // Abort in ADDR_HI.
    do_reset();
    bus_addr = 16'hA5C3; bus_data = 8'h3C;
    drive_strobes(req_strobes(1'b0, 1'b0));
    run_to(2, 3, "abort point");
    drive_strobes(4'b1111);
    step();
    check("abort", sample(), idle_obs(0, 8'hA5, 8'hFF));

    // Reset in the middle of a write data phase.
    do_reset();
    drive_strobes(req_strobes(1'b0, 1'b0));
    run_to(3, 4, "reset point");
    reset_n = 1'b0;
    step();
    check("mid-cycle reset", sample(), idle_obs(0, 8'h00, 8'hFF));
    reset_n = 1'b1;
    drive_strobes(4'b1111);

    // Back-to-back writes with a single idle cycle between them.
    do_reset();
    seq.delete();
    seq.push_back(state_demux);
    wr_n_cnt = 0;
    drive_strobes(req_strobes(1'b0, 1'b0));
    run_to(3, 2, "b2b first");
    wr_n_cnt += int'(!ex_bus_wr_n);
    drive_strobes(4'b1111);
    step_log();
    idle_n = 1;
    drive_strobes(req_strobes(1'b0, 1'b0));
    step_log();
    while (state_demux == 2'd0 && idle_n < 10) begin
      step_log();
      idle_n++;
    end
    check("b2b idle length", 32'(idle_n), 32'd1);
    run_to(3, 2, "b2b second");
    wr_n_cnt += int'(!ex_bus_wr_n);
    drive_strobes(4'b1111);
    step_log();
    check("b2b writes", 32'(wr_n_cnt), 32'd2);
    check("b2b seq length", 32'(seq.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < seq.size()) check($sformatf("b2b seq[%0d]", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Random cycles against the phase timeline model.
    do_reset();
    m_dout = 8'h00; m_cpu = 8'hFF;
    for (int n = 0; n < 40; n++) begin
      bit io, rd;
      int h, g;
      logic [7:0] pin;
      logic [3:0] s;
      io = 1'($urandom); rd = 1'($urandom);
      h = $urandom_range(2 * AC + 12, 1);
      g = $urandom_range(3, 1);
      for (int t = 1; t <= h; t++) begin
        if (t == 1) drive_strobes(req_strobes(io, rd));
        else drive_strobes(req_strobes(1'($urandom), 1'($urandom)));
        bus_addr = 16'($urandom); bus_data = 8'($urandom);
        pin = 8'($urandom); ex_bus_data_in = pin;
        if (t == 1) m_dout = bus_addr[7:0];
        if (t == AC + 1) m_dout = bus_addr[15:8];
        if (t == 2 * AC + 1 && !rd) m_dout = bus_data;
        if (phase_of(t) == 3 && rd && cnt_of(t) >= TURN) m_cpu = pin;
        step();
        check($sformatf("rand txn%0d t%0d", n, t), sample(), active_obs(t, io, rd, m_dout, m_cpu));
      end
      for (int k = 0; k < g; k++) begin
        s = 4'($urandom);
        while (is_req(s)) s = 4'($urandom);
        drive_strobes(s);
        bus_addr = 16'($urandom); bus_data = 8'($urandom); ex_bus_data_in = 8'($urandom);
        step();
        check($sformatf("rand txn%0d idle%0d", n, k), sample(), idle_obs(k, m_dout, m_cpu));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
